code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Serial boot loader that fills the CPU's 16-bit x 512-word code memory from a UART byte stream, then releases the processor.
- Drives the code-memory write port of the datapath (code_w_en, code_addr_in, code_in) and the run enable.
- Sits in the top-level beside the datapath. It is the initiator/writer end of the code-load interface that the datapath consumes.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 9, code memory address width.
- WORD_W, 16, code word width; fixed at 2 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial line; idle high; 8N1, LSB first.
- code_w_en  output  1  one-cycle write strobe to code memory.
- code_addr  output  ADDR_W  write address; valid while code_w_en=1.
- code_data  output  WORD_W  write data; valid while code_w_en=1.
- run  output  1  processor run enable (level).
- busy  output  1  a frame is in progress (SYNC accepted, not yet finished).
- load_err  output  1  sticky error flag; cleared when the next SYNC byte is accepted.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, address counter=0, checksum=0, byte receiver idle.
- Frame format:
  - SYNC byte 0xA5.
  - LEN_H, LEN_L: word count N, big-endian.
  - N words, each sent high byte then low byte.
  - CHK byte: XOR of LEN_H, LEN_L and all data bytes.
- Byte receiver:
  - uart_rx passes through a 2-flop synchronizer, preset to 1 on reset.
  - A falling edge in idle starts a bit counter. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the receiver aborts silently (glitch).
  - Data bits are sampled every CLKS_PER_BIT after that point.
  - Stop bit sampled high: byte_valid pulses for 1 cycle with the byte.
  - Stop bit sampled low: framing error pulses for 1 cycle.
- FSM states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK, RUN.
  - IDLE: only 0xA5 advances (to LEN_H). On that transition: load_err=0, busy=1, addr=0, chk=0. Other bytes are ignored.
  - LEN_H / LEN_L: latch N and XOR each byte into chk. After LEN_L: N==0 or N>2**ADDR_W → load_err=1, busy=0, go to IDLE; otherwise go to DATA_H.
  - DATA_H: latch the high byte, update chk, go to DATA_L.
  - DATA_L: in the cycle after the low byte's byte_valid, code_w_en=1, code_addr=addr, code_data={hi,lo}. addr then increments. If addr+1==N go to CHK, else go to DATA_H.
  - CHK: byte==chk → run=1, busy=0, go to RUN. Mismatch → load_err=1, busy=0, go to IDLE, run stays 0. Words already written are left in memory.
  - RUN: run held at 1. A 0xA5 byte drops run to 0 in the same cycle the byte is accepted, clears load_err, and goes to LEN_H (reload). Other bytes are ignored.
- Framing error in any state other than IDLE or RUN: load_err=1, busy=0, go to IDLE. In IDLE or RUN a framing error is ignored.
- Write strobe rules:
  - code_w_en is never high for 2 consecutive cycles.
  - code_w_en is never high while run=1.
  - At most N strobes are issued per frame.
- Address: counter is ADDR_W+1 bits wide internally so N=512 terminates correctly. code_addr is its low ADDR_W bits.
- Latency: a write strobe occurs 1 cycle after the stop-bit sample of the low byte. run rises 1 cycle after the stop-bit sample of CHK.
- Reset mid-frame: immediate return to reset state; partially written memory is not cleared.

Decomposition:
- Shared constants file (existing constants include): LOADER_SYNC=8'hA5, FSM state encodings (3-bit localparams), default CLKS_PER_BIT.
- One sub-module: uart_rx_byte (synchronizer, baud counter, shift register, byte_valid / frame_err pulses). code_loader holds the frame FSM, address counter, length register and checksum.

Test Plan:
- Nominal load, CLKS_PER_BIT=8. Send A5 00 02 12 34 AB CD, CHK=00^02^12^34^AB^CD=0x42.
  - Expect exactly 2 strobes: (addr 0, 0x1234), then (addr 1, 0xABCD).
  - run=1 one cycle after the CHK stop sample; load_err=0; busy low afterward.
- Bad checksum. Same frame with CHK=0x43.
  - Expect 2 strobes, then load_err=1, run=0, FSM in IDLE.
  - A following good frame clears load_err at its SYNC byte.
- Length boundaries.
  - LEN=0x0000 → load_err=1 after LEN_L, no strobes.
  - LEN=0x0201 → load_err=1, no strobes.
  - LEN=0x0200 with 512 words → strobes at addr 0..511, run=1.
- Framing error. Hold the stop bit low during DATA_L → load_err=1, no strobe for that word, busy=0.
- Reload and noise.
  - In RUN, send 0x55 → run stays 1.
  - Send A5 → run=0 in the acceptance cycle, busy=1.
  - A 1-cycle low glitch on uart_rx in IDLE produces no byte.
- Async reset mid-DATA_H: assert rst=0 asynchronously → outputs 0 immediately. After release, the receiver resynchronizes on the next full frame.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared constants and types for the serial code loader.
// Frame: A5, LEN_H, LEN_L, N x {hi, lo}, CHK (XOR of everything after SYNC).
package code_loader_pkg;

    localparam logic [7:0] LOADER_SYNC          = 8'hA5;
    localparam int         DEFAULT_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_H  = 3'd1;
    localparam logic [2:0] ST_LEN_L  = 3'd2;
    localparam logic [2:0] ST_DATA_H = 3'd3;
    localparam logic [2:0] ST_DATA_L = 3'd4;
    localparam logic [2:0] ST_CHK    = 3'd5;
    localparam logic [2:0] ST_RUN    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LEN_H  = ST_LEN_H,
        S_LEN_L  = ST_LEN_L,
        S_DATA_H = ST_DATA_H,
        S_DATA_L = ST_DATA_L,
        S_CHK    = ST_CHK,
        S_RUN    = ST_RUN
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // A word count is usable only if it is non-zero and fits the code memory.
    function automatic logic len_ok(input logic [15:0] n, input int addr_w);
        return (n != 16'd0) && (32'(n) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/code_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection,
// one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
    import code_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: synchronizer flops reset to the idle-high line level so leaving reset never looks like a start bit.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Start bit must still be low at mid-bit, otherwise it was a glitch.
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/code_loader.sv
// Boot loader: parses UART frames into code-memory writes, verifies the XOR
// checksum, then raises run. A SYNC byte while running starts a reload.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 9,
    parameter int WORD_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr,
    output logic [WORD_W-1:0] code_data,
    output logic              run,
    output logic              busy,
    output logic              load_err
);

    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          frame_err;

    loader_state_t state;
    logic [7:0]    len_h;
    logic [7:0]    hi_byte;
    logic [7:0]    chk;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] addr;
    logic [ADDR_W:0] addr_next;
    logic [15:0]   len_word;

    assign len_word  = {len_h, rx_byte};
    assign addr_next = addr + 1'b1;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len_h     <= '0;
            hi_byte   <= '0;
            chk       <= '0;
            n_words   <= '0;
            addr      <= '0;
            code_w_en <= 1'b0;
            code_addr <= '0;
            code_data <= '0;
            run       <= 1'b0;
            busy      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            code_w_en <= 1'b0;
            unique case (state)
                S_IDLE, S_RUN: begin
                    if (byte_valid && rx_byte == LOADER_SYNC) begin
                        state    <= S_LEN_H;
                        run      <= 1'b0;
                        busy     <= 1'b1;
                        load_err <= 1'b0;
                        addr     <= '0;
                        chk      <= '0;
                    end
                end
                S_LEN_H: begin
                    if (byte_valid) begin
                        len_h <= rx_byte;
                        chk   <= chk ^ rx_byte;
                        state <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (byte_valid) begin
                        chk <= chk ^ rx_byte;
                        if (len_ok(len_word, ADDR_W)) begin
                            n_words <= len_word[ADDR_W:0];
                            state   <= S_DATA_H;
                        end else begin
                            load_err <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_DATA_H: begin
                    if (byte_valid) begin
                        hi_byte <= rx_byte;
                        chk     <= chk ^ rx_byte;
                        state   <= S_DATA_L;
                    end
                end
                S_DATA_L: begin
                    if (byte_valid) begin
                        code_w_en <= 1'b1;
                        code_addr <= addr[ADDR_W-1:0];
                        code_data <= WORD_W'({hi_byte, rx_byte});
                        chk       <= chk ^ rx_byte;
                        addr      <= addr_next;
                        state     <= (addr_next == n_words) ? S_CHK : S_DATA_H;
                    end
                end
                S_CHK: begin
                    if (byte_valid) begin
                        busy <= 1'b0;
                        if (rx_byte == chk) begin
                            run   <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A broken byte mid-frame aborts the load; words already written stay in memory.
            if (frame_err && state != S_IDLE && state != S_RUN) begin
                load_err <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Randomized scoreboard bench for code_loader: a frame-level model queues the
// expected memory writes; a negedge monitor pops and compares every strobe.
module tb_code_loader;

    localparam int CPB    = 6;
    localparam int ADDR_W = 9;
    localparam int WORD_W = 16;
    localparam int GAP    = 2 * CPB;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              uart_rx = 1'b1;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr;
    logic [WORD_W-1:0] code_data;
    logic              run;
    logic              busy;
    logic              load_err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] words[$];
    logic        prev_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    code_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .WORD_W       (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .code_w_en (code_w_en),
        .code_addr (code_addr),
        .code_data (code_data),
        .run       (run),
        .busy      (busy),
        .load_err  (load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && code_w_en) begin
            check("strobe_not_back_to_back", 32'(prev_en), 32'd0);
            check("strobe_while_run", 32'(run), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%h expected no strobe", code_addr, code_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_addr", 32'(code_addr), 32'(mon_e.addr));
                check("strobe_data", 32'(code_data), 32'(mon_e.data));
            end
        end
        prev_en = code_w_en;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_val, input int gap, input bit run_low_check);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (run_low_check) check("run_low_before_chk_stop", 32'(run), 32'd0);
        uart_rx = stop_val;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    // Frame-level reference: decides the outcome from the frame contents alone.
    // fe_word >= 0 sends that word's low byte with a low stop bit and ends the frame there.
    task automatic run_frame(input logic [15:0] len, input bit bad_chk, input int fe_word,
                             input bit send_sync, input int gap);
        logic [7:0]  chk;
        logic [15:0] w;
        bit          valid;
        bit          exp_run;
        bit          exp_err;
        valid = (len != 16'd0) && (32'(len) <= (32'd1 << ADDR_W));
        if (send_sync) send_byte(8'hA5, 1'b1, gap, 1'b0);
        chk = len[15:8] ^ len[7:0];
        send_byte(len[15:8], 1'b1, gap, 1'b0);
        send_byte(len[7:0], 1'b1, gap, 1'b0);
        if (!valid) begin
            exp_run = 1'b0;
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                w   = words[i];
                chk = chk ^ w[15:8] ^ w[7:0];
                if (i != fe_word) exp_q.push_back('{addr: ADDR_W'(i), data: w});
                send_byte(w[15:8], 1'b1, gap, 1'b0);
                send_byte(w[7:0], i != fe_word, gap, 1'b0);
                if (i == fe_word) break;
            end
            if (fe_word >= 0) begin
                exp_run = 1'b0;
                exp_err = 1'b1;
            end else begin
                send_byte(bad_chk ? (chk ^ 8'h01) : chk, 1'b1, gap, 1'b1);
                exp_run = !bad_chk;
                exp_err = bad_chk;
            end
        end
        repeat (2 * CPB) @(negedge clk);
        check("frame_run", 32'(run), 32'(exp_run));
        check("frame_load_err", 32'(load_err), 32'(exp_err));
        check("frame_busy", 32'(busy), 32'd0);
        check("frame_strobes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code_w_en"}, 32'(code_w_en), 32'd0);
        check({tag, "_code_addr"}, 32'(code_addr), 32'd0);
        check({tag, "_code_data"}, 32'(code_data), 32'd0);
        check({tag, "_run"}, 32'(run), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal: A5 00 02 12 34 AB CD 42
        words = '{16'h1234, 16'hABCD};
        run_frame(16'd2, 1'b0, -1, 1'b1, GAP);

        // Non-SYNC byte in RUN is ignored
        send_byte(8'h55, 1'b1, GAP, 1'b0);
        check("run_holds_on_noise", 32'(run), 32'd1);
        check("busy_idle_on_noise", 32'(busy), 32'd0);

        // SYNC in RUN starts a reload
        send_byte(8'hA5, 1'b1, GAP, 1'b0);
        check("run_drops_on_sync", 32'(run), 32'd0);
        check("busy_on_reload", 32'(busy), 32'd1);
        fill_words(3);
        run_frame(16'd3, 1'b0, -1, 1'b0, GAP);

        // Bad checksum: words stay written, error flagged
        words = '{16'h1234, 16'hABCD};
        run_frame(16'd2, 1'b1, -1, 1'b1, GAP);

        // Next SYNC clears the sticky error
        send_byte(8'hA5, 1'b1, GAP, 1'b0);
        check("err_cleared_by_sync", 32'(load_err), 32'd0);
        check("busy_after_sync", 32'(busy), 32'd1);
        fill_words(2);
        run_frame(16'd2, 1'b0, -1, 1'b0, GAP);

        // Length boundaries
        run_frame(16'h0000, 1'b0, -1, 1'b1, GAP);
        run_frame(16'h0201, 1'b0, -1, 1'b1, GAP);

        // Framing error on the low byte of word 2
        fill_words(4);
        run_frame(16'd4, 1'b0, 2, 1'b1, GAP);

        // One-cycle glitch in IDLE must not desynchronize the next frame
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        fill_words(2);
        run_frame(16'd2, 1'b0, -1, 1'b1, GAP);

        // Asynchronous reset in the middle of DATA_H
        fill_words(2);
        send_byte(8'hA5, 1'b1, GAP, 1'b0);
        send_byte(8'h00, 1'b1, GAP, 1'b0);
        send_byte(8'h02, 1'b1, GAP, 1'b0);
        w = words[0];
        exp_q.push_back('{addr: ADDR_W'(0), data: w});
        send_byte(w[15:8], 1'b1, GAP, 1'b0);
        send_byte(w[7:0], 1'b1, GAP, 1'b0);
        check("word0_before_reset", 32'(exp_q.size()), 32'd0);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        fill_words(5);
        run_frame(16'd5, 1'b0, -1, 1'b1, GAP);

        // Full memory: 512 words, addresses 0..511
        fill_words(512);
        run_frame(16'h0200, 1'b0, -1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
